// File: rtl/udp_rx.sv
// UDP receive parser: strips the 8-byte UDP header from an IPv4 payload
// stream, filters on destination port and forwards the datagram payload
// with one cycle of latency. Padding beyond the UDP length is discarded.
module udp_rx #(
  parameter int          DATA_W = 16,
  parameter int          LEN_W  = $clog2(DATA_W/8),
  parameter logic [15:0] PORT   = 16'd18000
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              cancel_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [LEN_W-1:0]  len_o,
  output logic              last_o,
  output logic [15:0]       src_port_o,
  output logic              err_o,
  output logic              cancel_o
);

  localparam int         BYTES     = DATA_W / 8;
  localparam int         HDR_BEATS = 8 / BYTES;
  localparam logic [2:0] HDR_LAST  = 3'(HDR_BEATS - 1);

  typedef enum logic [1:0] {IDLE, HEAD, DATA, DROP} state_t;

  state_t              state_q, state_d;
  logic [2:0]          hcnt_q, hcnt_d;
  logic [47:0]         hdr_q, hdr_d;      // header bytes 0..5; checksum never stored
  logic [15:0]         rem_q, rem_d;
  logic                emitted_q, emitted_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                last_q, last_d;
  logic [15:0]         src_q, src_d;
  logic                err_q, err_d;
  logic                cancel_q, cancel_d;

  // Header view including the beat currently on data_i, so the final header
  // beat can be decided on without waiting a cycle.
  logic [47:0] hdr_cur;
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_hdr
      localparam logic [2:0] BEAT = 3'(gi / BYTES);
      localparam int         LANE = gi % BYTES;
      assign hdr_cur[gi*8 +: 8] = (hcnt_q == BEAT) ? data_i[LANE*8 +: 8] : hdr_q[gi*8 +: 8];
    end
  endgenerate

  logic [15:0] src_cur, dst_cur, ulen_cur;
  logic [16:0] beat_n;
  assign src_cur  = {hdr_cur[7:0],   hdr_cur[15:8]};
  assign dst_cur  = {hdr_cur[23:16], hdr_cur[31:24]};
  assign ulen_cur = {hdr_cur[39:32], hdr_cur[47:40]};
  assign beat_n   = 17'(len_i) + 17'd1;

  // Next-state and registered-output logic; cancel_i overrides everything.
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    hdr_d     = hdr_q;
    rem_d     = rem_q;
    emitted_d = emitted_q;
    valid_d   = 1'b0;
    data_d    = data_q;
    len_d     = len_q;
    last_d    = 1'b0;
    src_d     = src_q;
    err_d     = 1'b0;
    cancel_d  = 1'b0;
    if (cancel_i) begin
      state_d   = IDLE;
      hcnt_d    = 3'd0;
      cancel_d  = emitted_q;
      emitted_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            hdr_d     = hdr_cur;
            hcnt_d    = 3'd1;
            emitted_d = 1'b0;
            state_d   = HEAD;
          end
        end
        HEAD: begin
          if (!valid_i) begin
            err_d   = 1'b1;
            hcnt_d  = 3'd0;
            state_d = IDLE;
          end else begin
            hdr_d  = hdr_cur;
            hcnt_d = hcnt_q + 3'd1;
            if (hcnt_q == HDR_LAST) begin
              hcnt_d = 3'd0;
              if (dst_cur != PORT) begin
                state_d = DROP;
              end else if (ulen_cur < 16'd8) begin
                err_d   = 1'b1;
                state_d = DROP;
              end else if (ulen_cur == 16'd8) begin
                state_d = DROP;
              end else begin
                rem_d   = ulen_cur - 16'd8;
                src_d   = src_cur;
                state_d = DATA;
              end
            end
          end
        end
        DATA: begin
          if (!valid_i) begin
            err_d     = 1'b1;
            cancel_d  = emitted_q;
            emitted_d = 1'b0;
            state_d   = IDLE;
          end else begin
            valid_d   = 1'b1;
            data_d    = data_i;
            emitted_d = 1'b1;
            if ({1'b0, rem_q} <= beat_n) begin
              last_d  = 1'b1;
              len_d   = LEN_W'(rem_q - 16'd1);
              rem_d   = 16'd0;
              state_d = DROP;
            end else begin
              len_d = len_i;
              rem_d = rem_q - beat_n[15:0];
            end
          end
        end
        DROP: begin
          if (!valid_i) begin
            emitted_d = 1'b0;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= IDLE;
      hcnt_q    <= 3'd0;
      hdr_q     <= '0;
      rem_q     <= 16'd0;
      emitted_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      len_q     <= '0;
      last_q    <= 1'b0;
      src_q     <= 16'd0;
      err_q     <= 1'b0;
      cancel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      hdr_q     <= hdr_d;
      rem_q     <= rem_d;
      emitted_q <= emitted_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      len_q     <= len_d;
      last_q    <= last_d;
      src_q     <= src_d;
      err_q     <= err_d;
      cancel_q  <= cancel_d;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign len_o      = len_q;
  assign last_o     = last_q;
  assign src_port_o = src_q;
  assign err_o      = err_q;
  assign cancel_o   = cancel_q;

endmodule
